// File: rtl/day3_battery_joltage_sum.sv
`default_nettype none
// ============================================================================
//  Module   : day3_battery_joltage_sum
//  Purpose  : Parallel "max two-digit joltage per battery bank" solver.
//             Each of NUM_UNITS units consumes one decimal digit per enabled
//             cycle and tracks the largest number formed by an earlier digit
//             (tens) followed by a later digit (ones). A registered ternary
//             adder tree sums every unit result into joltage_sum.
//  Ports    : clock        - system clock, rising edge
//             reset        - synchronous, active-high
//             en           - digit-valid strobe for all units
//             next_battery - per-unit digit (0..9 valid, 10..15 ignored)
//             joltage_sum  - registered sum of unit results, zero-extended
//  Revision : 1.0 - initial release
// ============================================================================
module day3_battery_joltage_sum #(
  parameter int NUM_UNITS = 200
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [3:0]             next_battery [NUM_UNITS],
  output logic [NUM_UNITS+6:0]   joltage_sum
);

  // Number of ternary levels: smallest L >= 1 with 3^L >= NUM_UNITS.
  function automatic int calc_levels(input int n);
    int lv  = 1;
    int cap = 3;
    while (cap < n) begin
      cap = cap * 3;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  // Node count at a level; level 0 is the unit results themselves.
  function automatic int nodes_at(input int lvl);
    int n = NUM_UNITS;
    for (int i = 0; i < lvl; i++) n = (n + 2) / 3;
    return n;
  endfunction

  // Position of a level's first node inside the flat tree register array.
  function automatic int offset_of(input int lvl);
    int off = 0;
    for (int i = 1; i < lvl; i++) off = off + nodes_at(i);
    return off;
  endfunction

  localparam int c_out_w  = NUM_UNITS + 7;
  localparam int c_levels = calc_levels(NUM_UNITS);
  // Sum of three values grows by at most 2 bits per level. The sum never
  // exceeds 99*NUM_UNITS, so clamping to the output width is always safe.
  localparam int c_tree_w = (7 + 2 * c_levels > c_out_w) ? c_out_w : 7 + 2 * c_levels;
  localparam int c_total  = offset_of(c_levels + 1);

  // --------------------------------------------------------------------------
  // Per-unit digit trackers
  // --------------------------------------------------------------------------
  logic [6:0] r_best [NUM_UNITS];
  logic [3:0] r_hi   [NUM_UNITS];
  logic       r_seen [NUM_UNITS];
  logic [6:0] w_cand [NUM_UNITS];

  // Candidate pairs the best earlier digit with the incoming one. Only used
  // for valid digits, where it is at most 99.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_cand[i] = {3'b000, r_hi[i]} * 7'd10 + {3'b000, next_battery[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_best[i] <= '0;
        r_hi[i]   <= '0;
        r_seen[i] <= 1'b0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        // Codes 10..15 (e.g. a newline minus '0') leave the unit untouched.
        if (next_battery[i] <= 4'd9) begin
          if (r_seen[i] && (w_cand[i] > r_best[i])) r_best[i] <= w_cand[i];
          if (next_battery[i] > r_hi[i])            r_hi[i]   <= next_battery[i];
          r_seen[i] <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered ternary adder tree, all levels packed into one flat array
  // --------------------------------------------------------------------------
  logic [c_tree_w-1:0] r_tree [c_total];
  logic [c_tree_w-1:0] w_next [c_total];

  for (genvar l = 1; l <= c_levels; l++) begin : g_lvl
    localparam int c_nodes = nodes_at(l);
    localparam int c_prev  = nodes_at(l - 1);
    localparam int c_off   = offset_of(l);
    localparam int c_poff  = offset_of(l - 1);

    for (genvar j = 0; j < c_nodes; j++) begin : g_node
      logic [c_tree_w-1:0] w_in [3];

      for (genvar k = 0; k < 3; k++) begin : g_in
        if (3 * j + k >= c_prev) begin : g_pad
          assign w_in[k] = '0;
        end else if (l == 1) begin : g_leaf
          assign w_in[k] = c_tree_w'(r_best[3 * j + k]);
        end else begin : g_inner
          assign w_in[k] = r_tree[c_poff + 3 * j + k];
        end
      end

      assign w_next[c_off + j] = w_in[0] + w_in[1] + w_in[2];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tree <= '{default: '0};
    end else begin
      r_tree <= w_next;
    end
  end

  // The last entry is the single root node of the final level.
  assign joltage_sum = c_out_w'(r_tree[c_total-1]);

endmodule
`default_nettype wire

// File: tb/tb_day3_battery_joltage_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_day3_battery_joltage_sum
//  Purpose  : Directed self-checking bench for day3_battery_joltage_sum.
//             A 4-unit instance covers the functional cases; a 200-unit
//             instance covers the full-scale sum and its latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_day3_battery_joltage_sum;

  logic         clock = 1'b0;
  logic         reset;
  logic         en4;
  logic         en200;
  logic [3:0]   nb4   [4];
  logic [3:0]   nb200 [200];
  logic [10:0]  sum4;
  logic [206:0] sum200;

  int n_total = 0;
  int n_pass  = 0;

  string banks [4] = '{"987654321111111", "811111111111119",
                       "234234234234278", "818181911112111"};

  always #5 clock = ~clock;

  day3_battery_joltage_sum #(.NUM_UNITS(4)) dut4 (
    .clock        (clock),
    .reset        (reset),
    .en           (en4),
    .next_battery (nb4),
    .joltage_sum  (sum4)
  );

  day3_battery_joltage_sum #(.NUM_UNITS(200)) dut200 (
    .clock        (clock),
    .reset        (reset),
    .en           (en200),
    .next_battery (nb200),
    .joltage_sum  (sum200)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    nb4[0] = a;
    nb4[1] = b;
    nb4[2] = c;
    nb4[3] = d;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    // Reset held while digits are offered with en high: all must be discarded.
    reset = 1'b1;
    en4   = 1'b1;
    en200 = 1'b1;
    set4(4'd9, 4'd9, 4'd9, 4'd9);
    for (int i = 0; i < 200; i++) nb200[i] = 4'd9;
    tick(3);
    check("reset_hold4", sum4, 0);
    check("reset_hold200", sum200, 0);

    reset = 1'b0;
    en4   = 1'b0;
    en200 = 1'b0;
    tick(6);
    check("post_reset_idle4", sum4, 0);
    check("post_reset_idle200", sum200, 0);

    // Four banks of 15 digits, then the newline artefact, then idle.
    en4 = 1'b1;
    for (int p = 0; p < 15; p++) begin
      for (int u = 0; u < 4; u++) nb4[u] = 4'(banks[u][p] - 8'd48);
      tick(1);
    end
    set4(4'd10, 4'd10, 4'd10, 4'd10);
    tick(1);
    en4 = 1'b0;
    tick(3);
    check("banks_sum", sum4, 357);
    tick(10);
    check("banks_stable", sum4, 357);

    // Reset edge with a valid digit offered: output clears, digit dropped.
    reset = 1'b1;
    en4   = 1'b1;
    set4(4'd9, 4'd9, 4'd9, 4'd9);
    tick(1);
    reset = 1'b0;
    check("mid_reset_clear", sum4, 0);

    // u0: 1,12,5,15,3 -> 53   u1: 9,(gap),2 -> 92   u2: 1,9 -> 19   u3: 9,1 -> 91
    en4 = 1'b1; set4(4'd1,  4'd9,  4'd1,  4'd9);  tick(1);
    en4 = 1'b1; set4(4'd12, 4'd15, 4'd15, 4'd15); tick(1);
    en4 = 1'b0; set4(4'd9,  4'd9,  4'd9,  4'd9);  tick(3);
    check("en_gap_ignored", sum4, 0);
    en4 = 1'b1; set4(4'd5,  4'd2,  4'd9,  4'd1);  tick(1);
    en4 = 1'b1; set4(4'd15, 4'd15, 4'd15, 4'd15); tick(1);
    en4 = 1'b1; set4(4'd3,  4'd10, 4'd15, 4'd15); tick(1);
    en4 = 1'b0; set4(4'd9,  4'd9,  4'd9,  4'd9);  tick(3);
    check("mixed_streams_sum", sum4, 255);
    tick(5);
    check("en_low_hold", sum4, 255);

    // Single digit and empty banks give 0; u2 "5","5" gives 55.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    en4 = 1'b1; set4(4'd7,  4'd15, 4'd5, 4'd0); tick(1);
    en4 = 1'b1; set4(4'd15, 4'd15, 4'd5, 4'd0); tick(1);
    en4 = 1'b0;
    tick(1);
    check("latency_minus1", sum4, 0);
    tick(1);
    check("latency_exact", sum4, 55);
    tick(3);
    check("single_empty_sum", sum4, 55);

    // Full scale: every unit sees "99".
    en200 = 1'b1;
    for (int i = 0; i < 200; i++) nb200[i] = 4'd9;
    tick(2);
    en200 = 1'b0;
    tick(4);
    check("scale_latency_minus1", sum200, 0);
    tick(1);
    check("scale_sum", sum200, 19800);
    tick(10);
    check("scale_stable", sum200, 19800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
